quiz_scoreboard: RTL and testbench
==================================

// Module: quiz_scoreboard
// PURPOSE
//  Downstream result checker for the quiz-tester datapath. Consumes one
//  {x, y, z_true, z_test} sample per handshake and counts trials and mismatches.
//  Captures the first failing vector and issues a final pass/fail verdict
//  after NUM_TRIALS samples.
//  Replaces per-sample $monitor inspection with a synthesizable summary that
//  can be read from the FPGA.
// PARAMETERS
//  DATA_W      8    width of x, y, z_true, z_test
//  NUM_TRIALS  256  samples accepted per run (>=1)
//  CNT_W       16   width of trial/error counters; must hold NUM_TRIALS
// PORTS
//  clk             in   1       rising-edge clock, single domain
//  rst             in   1       synchronous, active-high reset
//  start           in   1       one-cycle pulse: begin a run (honoured in IDLE/DONE only)
//  in_valid        in   1       sample on x/y/z_true/z_test is valid
//  in_ready        out  1       scoreboard accepts a sample this cycle
//  x               in   DATA_W  stimulus operand x
//  y               in   DATA_W  stimulus operand y
//  z_true          in   DATA_W  golden-model result
//  z_test          in   DATA_W  design-under-test result
//  busy            out  1       run in progress (state RUN)
//  done            out  1       run complete, results stable (state DONE)
//  pass            out  1       done && err_cnt==0
//  trial_cnt       out  CNT_W   samples accepted this run
//  err_cnt         out  CNT_W   mismatches this run (saturating)
//  first_err_vld   out  1       first_err_* fields hold a captured failure
//  first_err_x     out  DATA_W  x of first mismatch
//  first_err_y     out  DATA_W  y of first mismatch
//  first_err_true  out  DATA_W  z_true of first mismatch
//  first_err_test  out  DATA_W  z_test of first mismatch
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs are 0, including in_ready, busy, done, pass,
//    counters and first_err_*.
//  - All outputs are registered, except in_ready = (state==RUN), which is a decode of the state reg.
//  - FSM IDLE --start--> RUN --(accept && trial_cnt==NUM_TRIALS-1)--> DONE --start--> RUN.
//  - On start (IDLE or DONE): next cycle clear trial_cnt, err_cnt and first_err_*; enter RUN.
//  - start while in RUN is ignored.
//  - accept = in_valid && in_ready. Upstream holds data stable while in_valid && !in_ready.
//  - On accept:
//      trial_cnt += 1
//      mismatch = (z_true != z_test), full DATA_W compare, no X-tolerance
//      on mismatch, err_cnt += 1, saturating at 2^CNT_W-1
//  - On the first mismatch of a run: latch x, y, z_true, z_test into first_err_*
//    and set first_err_vld. Later mismatches do not overwrite them.
//  - Latency: counters/first_err reflect an accepted sample on the next clk edge.
//  - On the last accept, done and pass assert on the next edge. That same edge drops
//    in_ready, so no sample NUM_TRIALS+1 is taken.
//  - DONE holds all results stable indefinitely. in_valid in DONE/IDLE is ignored.
//  - rst mid-run: abort to IDLE and clear everything on the same edge. rst has priority over start.
//  - start coincident with the final accept: the accept completes the run and the FSM
//    enters DONE. That start is dropped; it was issued while in RUN.
//  - NUM_TRIALS==1: the first accept moves the FSM straight to DONE.
// STRUCTURE
//  - quiz_pkg: state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2)
//    and the default DATA_W. Shared with the stimulus generator.
//  - Sub-module sat_counter #(W): sync clear, enable, saturating increment.
//    Instanced for err_cnt. trial_cnt uses a plain counter, bounded by the FSM.
//  - Remaining logic (FSM, first-error capture) lives in quiz_scoreboard.
// TESTING
//  - Reset then idle: with start=0, drive in_valid=1 for 10 cycles
//    -> in_ready=0, trial_cnt=0, done=0.
//  - All-match run, NUM_TRIALS=256: start, 256 accepts with z_test=z_true
//    -> done=1, pass=1, trial_cnt=256, err_cnt=0, first_err_vld=0.
//  - Mismatches at samples 5 and 9 (sample 5: x=8'h12, y=8'h34, z_true=8'h22, z_test=8'h23)
//    -> err_cnt=2, first_err_*={12,34,22,23}, pass=0.
//  - Backpressure/bubbles: in_valid toggled randomly ~50%
//    -> trial_cnt counts only accepts, and done follows accept #256 by exactly 1 cycle.
//  - rst asserted at trial 100 with err_cnt=3
//    -> next cycle state=IDLE, all counters 0. A new start gives a clean run.
//  - Restart from DONE, and start pulsed during RUN
//    -> restart clears the results; a start during RUN leaves trial_cnt unchanged and continues.

Source files
------------

// File: rtl/quiz_pkg.sv
// quiz_pkg: shared scoreboard state encoding and default data width,
// also used by the stimulus generator.
package quiz_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
   localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear and enable that sticks at
// its all-ones maximum instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_q <= '0;
      else if (i_en && r_q != '1) r_q <= r_q + W'(1);
   end
   assign o_q = r_q;
endmodule

// File: rtl/quiz_scoreboard.sv
// quiz_scoreboard: counts trials and mismatches of golden vs tested results,
// captures the first failing vector and reports a verdict after NUM_TRIALS.
module quiz_scoreboard #(
   parameter int DATA_W     = quiz_pkg::DATA_W_DEF,
   parameter int NUM_TRIALS = 256,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [DATA_W-1:0] z_true,
   input  logic [DATA_W-1:0] z_test,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  trial_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              first_err_vld,
   output logic [DATA_W-1:0] first_err_x,
   output logic [DATA_W-1:0] first_err_y,
   output logic [DATA_W-1:0] first_err_true,
   output logic [DATA_W-1:0] first_err_test
);
   import quiz_pkg::*;
   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_trial, w_err;
   logic              r_busy, r_done, r_pass, r_vld;
   logic [DATA_W-1:0] r_fx, r_fy, r_ft, r_fs;
   logic              w_start_ok, w_acc, w_mis, w_last, w_busy_nxt, w_done_nxt, w_pass_nxt;
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else r_state <= w_state_nxt;
   end
   // a start seen in RUN is dropped, even when it coincides with the final accept
   always_comb begin
      w_start_ok  = start && r_state != ST_RUN;
      w_acc       = in_valid && r_state == ST_RUN;
      w_mis       = w_acc && (z_true != z_test);
      w_last      = w_acc && r_trial == CNT_W'(NUM_TRIALS - 1);
      w_state_nxt = w_start_ok ? ST_RUN : w_last ? ST_DONE : r_state;
      w_busy_nxt  = w_state_nxt == ST_RUN;
      w_done_nxt  = w_state_nxt == ST_DONE;
      w_pass_nxt  = w_done_nxt && (r_state == ST_DONE ? r_pass : (w_err == '0 && !w_mis));
   end
   sat_counter #(.W(CNT_W)) u_err (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start_ok),
      .i_en  (w_mis),
      .o_q   (w_err)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_trial <= '0;
         r_vld   <= 1'b0;
         r_fx    <= '0;
         r_fy    <= '0;
         r_ft    <= '0;
         r_fs    <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
         r_trial <= w_start_ok ? '0 : w_acc ? r_trial + CNT_W'(1) : r_trial;
         if (w_start_ok) begin
            r_vld <= 1'b0;
            r_fx  <= '0;
            r_fy  <= '0;
            r_ft  <= '0;
            r_fs  <= '0;
         end else if (w_mis && !r_vld) begin
            r_vld <= 1'b1;
            r_fx  <= x;
            r_fy  <= y;
            r_ft  <= z_true;
            r_fs  <= z_test;
         end
      end
   end
   assign in_ready       = r_state == ST_RUN;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign trial_cnt      = r_trial;
   assign err_cnt        = w_err;
   assign first_err_vld  = r_vld;
   assign first_err_x    = r_fx;
   assign first_err_y    = r_fy;
   assign first_err_true = r_ft;
   assign first_err_test = r_fs;
endmodule

// File: tb/tb_quiz_scoreboard.sv
// tb_quiz_scoreboard: randomized stimulus against a queue-based model that
// derives every expected output from the list of samples accepted this run.
module tb_quiz_scoreboard;
   localparam int DW = 8;
   localparam int N  = 256;
   localparam int CW = 16;
   logic          clk = 1'b0;
   logic          rst, start, in_valid, in_ready;
   logic [DW-1:0] x, y, z_true, z_test;
   logic          busy, done, pass, first_err_vld;
   logic [CW-1:0] trial_cnt, err_cnt;
   logic [DW-1:0] first_err_x, first_err_y, first_err_true, first_err_test;
   typedef struct packed {logic [DW-1:0] x, y, t, s;} smp_t;
   smp_t q[$];
   bit   m_run, m_done;
   int   checks, errors;
   quiz_scoreboard #(.DATA_W(DW), .NUM_TRIALS(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .z_true(z_true), .z_test(z_test),
      .busy(busy), .done(done), .pass(pass), .trial_cnt(trial_cnt), .err_cnt(err_cnt),
      .first_err_vld(first_err_vld), .first_err_x(first_err_x), .first_err_y(first_err_y),
      .first_err_true(first_err_true), .first_err_test(first_err_test)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   function automatic int m_errs();
      int n = 0;
      foreach (q[i]) if (q[i].t != q[i].s) n++;
      return n > 65535 ? 65535 : n;
   endfunction
   function automatic int m_first();
      foreach (q[i]) if (q[i].t != q[i].s) return i;
      return -1;
   endfunction
   task automatic verify();
      int f;
      smp_t e;
      f = m_first();
      e = (f >= 0) ? q[f] : '0;
      check("in_ready", 32'(in_ready), 32'(m_run));
      check("busy", 32'(busy), 32'(m_run));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_done && m_errs() == 0));
      check("trial_cnt", 32'(trial_cnt), 32'(q.size()));
      check("err_cnt", 32'(err_cnt), 32'(m_errs()));
      check("first_vld", 32'(first_err_vld), 32'(f >= 0));
      check("first_x", 32'(first_err_x), 32'(e.x));
      check("first_y", 32'(first_err_y), 32'(e.y));
      check("first_true", 32'(first_err_true), 32'(e.t));
      check("first_test", 32'(first_err_test), 32'(e.s));
   endtask
   task automatic cyc(input bit r, input bit s, input bit v, input smp_t d);
      rst = r; start = s; in_valid = v;
      x = d.x; y = d.y; z_true = d.t; z_test = d.s;
      @(posedge clk);
      if (r) begin
         q.delete(); m_run = 0; m_done = 0;
      end else if (s && !m_run) begin
         q.delete(); m_run = 1; m_done = 0;
      end else if (m_run && v) begin
         q.push_back(d);
         if (q.size() == N) begin m_run = 0; m_done = 1; end
      end
      #1 verify();
   endtask
   function automatic smp_t rnd(input bit mis);
      smp_t d;
      d.x = 8'($urandom); d.y = 8'($urandom); d.t = 8'($urandom);
      d.s = mis ? d.t ^ 8'($urandom_range(255, 1)) : d.t;
      return d;
   endfunction
   initial begin
      smp_t d;
      checks = 0; errors = 0;
      cyc(1, 0, 0, '0);
      cyc(1, 0, 0, '0);
      for (int k = 0; k < 10; k++) cyc(0, 0, 1, rnd(1));
      check("idle_ready", 32'(in_ready), 32'(0));
      // all-match run, valid held high
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 2 * N && !m_done; k++) cyc(0, 0, 1, rnd(0));
      check("all_done", 32'(done), 32'(1));
      check("all_pass", 32'(pass), 32'(1));
      check("all_trials", 32'(trial_cnt), 32'(N));
      for (int k = 0; k < 5; k++) cyc(0, 0, 1, rnd(1));
      // mismatches at samples 5 and 9
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 2 * N && !m_done; k++) begin
         d = rnd(q.size() == 8);
         if (q.size() == 4) d = '{8'h12, 8'h34, 8'h22, 8'h23};
         cyc(0, 0, 1, d);
      end
      check("mm_err", 32'(err_cnt), 32'(2));
      check("mm_fx", 32'(first_err_x), 32'h12);
      check("mm_fy", 32'(first_err_y), 32'h34);
      check("mm_ft", 32'(first_err_true), 32'h22);
      check("mm_fs", 32'(first_err_test), 32'h23);
      check("mm_pass", 32'(pass), 32'(0));
      // restart from DONE with bubbles, stray starts, and a start on the final accept
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 8 * N && !m_done; k++) begin
         bit v;
         v = 1'($urandom_range(1, 0));
         cyc(0, (v && q.size() == N - 1) || $urandom_range(19, 0) == 0, v, rnd($urandom_range(9, 0) == 0));
      end
      check("bp_done", 32'(done), 32'(1));
      // reset mid-run at trial 100 with three errors
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 1000 && q.size() < 100; k++)
         cyc(0, 0, 1, rnd(q.size() == 10 || q.size() == 40 || q.size() == 70));
      check("pre_rst_trials", 32'(trial_cnt), 32'(100));
      check("pre_rst_err", 32'(err_cnt), 32'(3));
      cyc(1, 1, 1, rnd(1));
      check("rst_trials", 32'(trial_cnt), 32'(0));
      cyc(0, 0, 1, rnd(1));
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 8 * N && !m_done; k++)
         cyc(0, 0, 1'($urandom_range(1, 0)), rnd($urandom_range(15, 0) == 0));
      check("clean_done", 32'(done), 32'(1));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
